vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 88 ++++++++
 tb/tb_vga_timing_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing with pixel-rate divider and registered decodes.
//   clk            system clock (CLK_50 at top level)
//   Reset          synchronous active-high reset
//   CounterX/Y     current pixel column / line
//   vga_h_sync/v   active-low sync pulses
//   inDisplayArea  high inside the visible window
//   pix_tick       high in the first clk of each pixel period
//   frame_start    one-clk pulse at the first clk of pixel (0,0)
//   frame_cnt      completed frames since reset when VGA_FRAME_CNT_EN is defined, else 0
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIX_DIV   = 2
) (
  input  logic       clk,
  input  logic       Reset,
  output logic [9:0] CounterX,
  output logic [9:0] CounterY,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic       inDisplayArea,
  output logic       pix_tick,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [3:0] PH_LAST = 4'(PIX_DIV - 1);
  // run is low only in the first clk after reset, so pixel (0,0) is presented
  // at E0 without advancing past it.
  logic       run, adv, wrap_x, top;
  logic [3:0] ph;
  logic [9:0] x_n, y_n;
  always_comb begin
    adv    = !run || ph == PH_LAST;
    wrap_x = CounterX == H_LAST;
    x_n    = !run ? 10'd0 : !adv ? CounterX : wrap_x ? 10'd0 : CounterX + 10'd1;
    y_n    = !run ? 10'd0 : !(adv && wrap_x) ? CounterY : CounterY == V_LAST ? 10'd0 : CounterY + 10'd1;
    top    = adv && x_n == 10'd0 && y_n == 10'd0;
  end
  // Decodes use the next counter values so every output changes on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (Reset) begin
      run           <= 1'b0;
      ph            <= 4'd0;
      CounterX      <= 10'd0;
      CounterY      <= 10'd0;
      vga_h_sync    <= 1'b1;
      vga_v_sync    <= 1'b1;
      inDisplayArea <= 1'b0;
      pix_tick      <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      run           <= 1'b1;
      ph            <= adv ? 4'd0 : ph + 4'd1;
      CounterX      <= x_n;
      CounterY      <= y_n;
      vga_h_sync    <= !(x_n >= HS_LO && x_n <= HS_HI);
      vga_v_sync    <= !(y_n >= VS_LO && y_n <= VS_HI);
      inDisplayArea <= x_n < H_VIS && y_n < V_VIS;
      pix_tick      <= adv;
      frame_start   <= top;
    end
  end
`ifdef VGA_FRAME_CNT_EN
  // The frame_start issued at E0 opens the first frame and completes none.
  always_ff @(posedge clk) begin
    if (Reset) frame_cnt <= 8'd0;
    else if (top && run) frame_cnt <= frame_cnt + 8'd1;
  end
`else
  assign frame_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized self-checking bench against an arithmetic raster model.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  int t = -1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  // t = clks elapsed since E0 (0 right after E0), -1 while held in reset.
  always @(posedge clk) t <= Reset ? -1 : t + 1;

  logic [9:0] xa, ya, xb, yb, xc, yc;
  logic hsa, vsa, dea, pta, fsa, hsb, vsb, deb, ptb, fsb, hsc, vsc, dec, ptc, fsc;
  logic [7:0] fca, fcb, fcc;
  logic [33:0] oa, ob, oc;
  assign oa = {xa, ya, hsa, vsa, dea, pta, fsa, fca};
  assign ob = {xb, yb, hsb, vsb, deb, ptb, fsb, fcb};
  assign oc = {xc, yc, hsc, vsc, dec, ptc, fsc, fcc};

  vga_timing_gen u_a (.clk(clk), .Reset(Reset), .CounterX(xa), .CounterY(ya), .vga_h_sync(hsa),
    .vga_v_sync(vsa), .inDisplayArea(dea), .pix_tick(pta), .frame_start(fsa), .frame_cnt(fca));
  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_VISIBLE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .PIX_DIV(1)) u_b (.clk(clk), .Reset(Reset), .CounterX(xb), .CounterY(yb),
    .vga_h_sync(hsb), .vga_v_sync(vsb), .inDisplayArea(deb), .pix_tick(ptb), .frame_start(fsb), .frame_cnt(fcb));
  vga_timing_gen #(.H_VISIBLE(40), .H_FP(4), .H_SYNC(8), .H_BP(6), .V_VISIBLE(20), .V_FP(2),
    .V_SYNC(3), .V_BP(4), .PIX_DIV(5)) u_c (.clk(clk), .Reset(Reset), .CounterX(xc), .CounterY(yc),
    .vga_h_sync(hsc), .vga_v_sync(vsc), .inDisplayArea(dec), .pix_tick(ptc), .frame_start(fsc), .frame_cnt(fcc));

  localparam int B_FRAME = 14 * 7;
  localparam int C_FRAME = 58 * 29 * 5;

  // Expected {x, y, hs, vs, de, tick, fs, fcnt} from elapsed clks by plain division.
  function automatic logic [33:0] model(int tt, int hv, int hf, int hsw, int hb,
                                        int vv, int vf, int vsw, int vb, int pd);
    int ht, vt, n, x, y, f;
    logic [7:0] fc;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (tt < 0) return {20'd0, 2'b11, 3'b000, 8'd0};
    n = tt / pd;
    x = n % ht;
    y = (n / ht) % vt;
    f = n / (ht * vt);
    fc = 8'd0;
`ifdef VGA_FRAME_CNT_EN
    fc = 8'(f % 256);
`endif
    return {10'(x), 10'(y), !(x >= hv + hf && x < hv + hf + hsw), !(y >= vv + vf && y < vv + vf + vsw),
            x < hv && y < vv, tt % pd == 0, tt % pd == 0 && n % (ht * vt) == 0, fc};
  endfunction
  function automatic logic [33:0] ma(int tt); return model(tt, 640, 16, 96, 48, 480, 10, 2, 33, 2); endfunction
  function automatic logic [33:0] mb(int tt); return model(tt, 8, 2, 2, 2, 4, 1, 1, 1, 1); endfunction
  function automatic logic [33:0] mc(int tt); return model(tt, 40, 4, 8, 6, 20, 2, 3, 4, 5); endfunction

  task automatic restart;
    Reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_chk += 3;
      if (oa !== ma(t)) begin n_fail++; $display("FAIL reset_a t=%0d got=%h exp=%h", t, oa, ma(t)); end
      if (ob !== mb(t)) begin n_fail++; $display("FAIL reset_b t=%0d got=%h exp=%h", t, ob, mb(t)); end
      if (oc !== mc(t)) begin n_fail++; $display("FAIL reset_c t=%0d got=%h exp=%h", t, oc, mc(t)); end
    end
  endtask

  task automatic test_line;
    int hl = 0;
    restart();
    repeat (3300) begin
      @(negedge clk);
      n_chk++;
      if (oa !== ma(t)) begin n_fail++; $display("FAIL line_a t=%0d got=%h exp=%h", t, oa, ma(t)); end
      if (t < 1600 && !hsa) hl++;
      if (t == 2) begin
        n_chk++;
        if (xa !== 10'd1) begin n_fail++; $display("FAIL line_x_at_e2 got=%0d exp=1", xa); end
      end
      if (t == 1600) begin
        n_chk++;
        if (ya !== 10'd1) begin n_fail++; $display("FAIL line_y_at_e1600 got=%0d exp=1", ya); end
      end
    end
    n_chk++;
    if (hl != 96 * 2) begin n_fail++; $display("FAIL line_hsync_width got=%0d exp=%0d", hl, 96 * 2); end
  endtask

  task automatic test_frame;
    int vl = 0;
    int fs_q[$];
    restart();
    repeat (2 * C_FRAME + 20) begin
      @(negedge clk);
      n_chk++;
      if (oc !== mc(t)) begin n_fail++; $display("FAIL frame_c t=%0d got=%h exp=%h", t, oc, mc(t)); end
      if (t < C_FRAME && !vsc) vl++;
      if (fsc) fs_q.push_back(t);
    end
    n_chk += 2;
    if (vl != 3 * 58 * 5) begin n_fail++; $display("FAIL frame_vsync_width got=%0d exp=%0d", vl, 3 * 58 * 5); end
    if (fs_q.size() != 3 || fs_q[1] - fs_q[0] != C_FRAME)
      begin n_fail++; $display("FAIL frame_period starts=%0d got=%0d exp=%0d", fs_q.size(),
                               fs_q.size() > 1 ? fs_q[1] - fs_q[0] : -1, C_FRAME); end
  endtask

  task automatic test_small;
    int ticks = 0;
    int frames = 0;
    restart();
    repeat (300) begin
      @(negedge clk);
      n_chk++;
      if (ob !== mb(t)) begin n_fail++; $display("FAIL small_b t=%0d got=%h exp=%h", t, ob, mb(t)); end
      if (ptb) ticks++;
      if (fsb) frames++;
    end
    n_chk += 2;
    if (ticks != 300) begin n_fail++; $display("FAIL small_ticks got=%0d exp=300", ticks); end
    if (frames != 300 / B_FRAME + 1) begin n_fail++; $display("FAIL small_frames got=%0d exp=%0d", frames, 300 / B_FRAME + 1); end
  endtask

  task automatic test_mid_reset;
    restart();
    for (int k = 0; k < 6; k++) begin
      int len, w;
      len = (k == 0) ? 2202 : int'($urandom_range(20, 3000));
      w = int'($urandom_range(1, 3));
      repeat (len) begin
        @(negedge clk);
        n_chk += 3;
        if (oa !== ma(t)) begin n_fail++; $display("FAIL midrst_a t=%0d got=%h exp=%h", t, oa, ma(t)); end
        if (ob !== mb(t)) begin n_fail++; $display("FAIL midrst_b t=%0d got=%h exp=%h", t, ob, mb(t)); end
        if (oc !== mc(t)) begin n_fail++; $display("FAIL midrst_c t=%0d got=%h exp=%h", t, oc, mc(t)); end
      end
      Reset = 1'b1;
      repeat (w) begin
        @(negedge clk);
        n_chk++;
        if (oa !== ma(-1)) begin n_fail++; $display("FAIL midrst_hold_a got=%h exp=%h", oa, ma(-1)); end
      end
      Reset = 1'b0;
      repeat (50) begin
        @(negedge clk);
        n_chk += 3;
        if (oa !== ma(t)) begin n_fail++; $display("FAIL midrst_rec_a t=%0d got=%h exp=%h", t, oa, ma(t)); end
        if (ob !== mb(t)) begin n_fail++; $display("FAIL midrst_rec_b t=%0d got=%h exp=%h", t, ob, mb(t)); end
        if (oc !== mc(t)) begin n_fail++; $display("FAIL midrst_rec_c t=%0d got=%h exp=%h", t, oc, mc(t)); end
      end
    end
  endtask

  task automatic test_frame_cnt;
    logic [7:0] e255, e0;
`ifdef VGA_FRAME_CNT_EN
    e255 = 8'd255;
`else
    e255 = 8'd0;
`endif
    e0 = 8'd0;
    restart();
    repeat (257 * B_FRAME + 5) begin
      @(negedge clk);
      n_chk++;
      if (ob !== mb(t)) begin n_fail++; $display("FAIL fcnt_b t=%0d got=%h exp=%h", t, ob, mb(t)); end
      if (t == 10) begin
        n_chk++;
        if (fcb !== e0) begin n_fail++; $display("FAIL fcnt_frame1 got=%0d exp=%0d", fcb, e0); end
      end
      if (t == 255 * B_FRAME) begin
        n_chk++;
        if (fcb !== e255) begin n_fail++; $display("FAIL fcnt_frame256 got=%0d exp=%0d", fcb, e255); end
      end
      if (t == 256 * B_FRAME) begin
        n_chk++;
        if (fcb !== e0) begin n_fail++; $display("FAIL fcnt_wrap got=%0d exp=%0d", fcb, e0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_small();
    test_mid_reset();
    test_frame_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
